led_pwm_dimmer: RTL and testbench

Brightness stage placed directly downstream of the free-running LED pattern counter on the board. It registers the 8-bit pattern, gates it with a PWM enable derived from a 3-bit brightness level, and drives the physical LEDs. Two raw push-buttons raise and lower the level; each button is synchronised and debounced, and only its rising edge is acted upon.

---
 rtl/led_pwm_dimmer.sv | 107 ++++++++++
 tb/tb_led_pwm_dimmer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_dimmer.sv
// rtl/led_pwm_dimmer.sv - registered LED pattern gated by a button-controlled 8-step PWM
module led_pwm_dimmer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int PWM_DIV         = 1024
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] pattern_in,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [7:0] led_out,
   output logic [2:0] level
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
   localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [PW-1:0] PRESC_MAX = PW'(PWM_DIV - 1);

   // index 0 = up button, index 1 = down button
   logic [1:0]    btn_raw;
   logic [1:0]    sync1;
   logic [1:0]    sync2;
   logic [1:0]    deb;
   logic [1:0]    deb_d;
   logic [1:0]    pulse;
   logic [DW-1:0] deb_cnt [2];

   logic [7:0]    pattern_q;
   logic [PW-1:0] presc;
   logic [2:0]    pwm_phase;
   logic          pwm_on;
   logic          up_p;
   logic          dn_p;

   assign btn_raw = {btn_down, btn_up};
   assign up_p    = pulse[0];
   assign dn_p    = pulse[1];

   // Synchronise, debounce and rising-edge detect both buttons; the counter
   // must see DEBOUNCE_CYCLES consecutive mismatches before the state flips.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 2'b00;
         sync2 <= 2'b00;
         deb   <= 2'b00;
         deb_d <= 2'b00;
         pulse <= 2'b00;
         for (int i = 0; i < 2; i++) begin
            deb_cnt[i] <= '0;
         end
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         deb_d <= deb;
         pulse <= deb & ~deb_d;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == deb[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_MAX) begin
               deb[i]     <= sync2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Saturating brightness level; simultaneous up and down cancel out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level <= 3'd3;
      end else if (up_p && !dn_p && level != 3'd7) begin
         level <= level + 3'd1;
      end else if (dn_p && !up_p && level != 3'd0) begin
         level <= level - 3'd1;
      end
   end

   // Free-running prescaler and 8-step PWM phase; never restarted on level change.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc     <= '0;
         pwm_phase <= 3'd0;
      end else if (presc == PRESC_MAX) begin
         presc     <= '0;
         pwm_phase <= pwm_phase + 3'd1;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   assign pwm_on = (pwm_phase <= level);

   // Register the upstream pattern, then gate it onto the LED pins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pattern_q <= 8'h00;
         led_out   <= 8'h00;
      end else begin
         pattern_q <= pattern_in;
         led_out   <= pwm_on ? pattern_q : 8'h00;
      end
   end

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// tb/tb_led_pwm_dimmer.sv - self-checking bench for led_pwm_dimmer
module tb_led_pwm_dimmer;

   localparam int DEB = 4;
   localparam int DIV = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] pattern_in = 8'h00;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic [7:0] led_out;
   logic [2:0] level;

   always #5 clk = ~clk;

   led_pwm_dimmer #(
      .DEBOUNCE_CYCLES(DEB),
      .PWM_DIV        (DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .pattern_in(pattern_in),
      .btn_up    (btn_up),
      .btn_down  (btn_down),
      .led_out   (led_out),
      .level     (level)
   );

   int checks = 0;
   int failures = 0;

   function automatic void check(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Scoreboard: expected led_out pushed when the pattern is captured,
   // popped when the corresponding registered output is due.
   typedef struct {
      int         due;
      logic [7:0] exp;
   } sb_t;

   sb_t        sbq[$];
   sb_t        sb_push;
   sb_t        sb_pop;
   int         cyc;
   int         edge_no;
   bit         sb_on = 1'b0;
   logic [2:0] exp_lvl = 3'd3;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc <= 0;
         sbq.delete();
      end else begin
         if (sb_on) begin
            edge_no      = cyc + 1;
            sb_push.due  = edge_no + 1;
            sb_push.exp  = (((edge_no / DIV) % 8) <= int'(exp_lvl)) ? pattern_in : 8'h00;
            sbq.push_back(sb_push);
         end
         cyc <= cyc + 1;
      end
   end

   always @(negedge clk) begin
      if (!rst && sbq.size() > 0 && sbq[0].due <= cyc) begin
         sb_pop = sbq.pop_front();
         if (sb_pop.due < cyc) check("sb_stale", sb_pop.due, cyc);
         else check("sb_led", int'(led_out), int'(sb_pop.exp));
      end
   end

   typedef struct {
      logic       up;
      logic       dn;
      int         hi;
      int         lo;
      logic [2:0] exp_level;
   } btn_vec_t;

   btn_vec_t vecs[20];

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_vec(input btn_vec_t v, input int idx);
      btn_up   = v.up;
      btn_down = v.dn;
      tick(v.hi);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      tick(v.lo);
      check($sformatf("vec%0d_level", idx), int'(level), int'(v.exp_level));
   endtask

   task automatic count_on(input int n, output int on);
      on = 0;
      repeat (n) begin
         @(negedge clk);
         if (led_out != 8'h00) on++;
      end
   endtask

   int on_cnt;
   bit found;

   initial begin
      // 0-5: up presses from 3 saturating at 7; 6-8: short glitches on down
      vecs[0]  = '{1'b1, 1'b0, 10, 10, 3'd4};
      vecs[1]  = '{1'b1, 1'b0, 10, 10, 3'd5};
      vecs[2]  = '{1'b1, 1'b0, 10, 10, 3'd6};
      vecs[3]  = '{1'b1, 1'b0, 10, 10, 3'd7};
      vecs[4]  = '{1'b1, 1'b0, 10, 10, 3'd7};
      vecs[5]  = '{1'b1, 1'b0, 10, 10, 3'd7};
      vecs[6]  = '{1'b0, 1'b1, 3, 3, 3'd7};
      vecs[7]  = '{1'b0, 1'b1, 3, 3, 3'd7};
      vecs[8]  = '{1'b0, 1'b1, 3, 10, 3'd7};
      // 9-17: down presses saturating at 0
      vecs[9]  = '{1'b0, 1'b1, 10, 10, 3'd6};
      vecs[10] = '{1'b0, 1'b1, 10, 10, 3'd5};
      vecs[11] = '{1'b0, 1'b1, 10, 10, 3'd4};
      vecs[12] = '{1'b0, 1'b1, 10, 10, 3'd3};
      vecs[13] = '{1'b0, 1'b1, 10, 10, 3'd2};
      vecs[14] = '{1'b0, 1'b1, 10, 10, 3'd1};
      vecs[15] = '{1'b0, 1'b1, 10, 10, 3'd0};
      vecs[16] = '{1'b0, 1'b1, 10, 10, 3'd0};
      vecs[17] = '{1'b0, 1'b1, 10, 10, 3'd0};
      // 18: one up; 19: simultaneous up and down
      vecs[18] = '{1'b1, 1'b0, 10, 10, 3'd1};
      vecs[19] = '{1'b1, 1'b1, 10, 10, 3'd1};

      // Reset state and level-3 duty cycle
      pattern_in = 8'hAA;
      tick(2);
      check("rst_led", int'(led_out), 8'h00);
      check("rst_level", int'(level), 3);
      rst     = 1'b0;
      exp_lvl = 3'd3;
      sb_on   = 1'b1;
      tick(2);
      count_on(16, on_cnt);
      check("duty_level3", on_cnt, 8);
      sb_on = 1'b0;
      tick(2);

      // Single up press: exact latency, one increment, release ignored
      btn_up = 1'b1;
      tick(7);
      check("up_before", int'(level), 3);
      tick(1);
      check("up_after", int'(level), 4);
      tick(12);
      btn_up = 1'b0;
      tick(12);
      check("up_release", int'(level), 4);

      // Asynchronous reset mid-cycle while LEDs are lit
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (led_out != 8'h00) found = 1'b1;
      end
      check("led_lit_seen", int'(found), 1);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst_led", int'(led_out), 8'h00);
      check("async_rst_level", int'(level), 3);
      tick(2);
      rst = 1'b0;
      tick(2);

      // Up saturation and glitch rejection
      for (int i = 0; i <= 8; i++) apply_vec(vecs[i], i);

      // Level 7: always on, 2-cycle pattern latency
      exp_lvl    = 3'd7;
      pattern_in = 8'h0F;
      sb_on      = 1'b1;
      tick(4);
      check("lat_pre", int'(led_out), 8'h0F);
      pattern_in = 8'hF0;
      tick(1);
      check("lat_1", int'(led_out), 8'h0F);
      tick(1);
      check("lat_2", int'(led_out), 8'hF0);
      count_on(16, on_cnt);
      check("duty_level7", on_cnt, 16);
      sb_on = 1'b0;
      tick(2);

      // Down saturation, level-0 duty
      for (int i = 9; i <= 17; i++) apply_vec(vecs[i], i);
      exp_lvl = 3'd0;
      sb_on   = 1'b1;
      tick(2);
      count_on(16, on_cnt);
      check("duty_level0", on_cnt, 2);
      sb_on = 1'b0;
      tick(2);

      // Simultaneous presses cancel
      for (int i = 18; i <= 19; i++) apply_vec(vecs[i], i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
